prog_loader: RTL and testbench

- Writer side of the instruction path. Receives a program as a byte stream from the UART receiver and packs each pair of bytes into one instruction word {op_code, operand}.
- Writes each word sequentially into program memory from address 0. The instruction decoder later consumes these words.
- Validates every op_code against the implemented set (HLT..SUBI, 0..7). Terminates cleanly when HLT is written.

---
 rtl/prog_loader.sv | 132 +++++++++++++
 tb/tb_prog_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: packs UART bytes into instruction words {op_code, operand}
// and writes them sequentially into program memory from address 0.
// A session starts on i_start and ends cleanly on HLT (op_code 0), or
// with an error on an unimplemented op_code or on memory overflow.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | no session since reset, waiting for i_start
// S_WAIT_HI | collecting the high byte (op_code in bits 7:3)
// S_WAIT_LO | collecting the low byte, word written on the next edge
// S_DONE    | HLT written, o_done held until the next i_start
// S_ERR     | invalid op_code or overflow, o_err held until i_start
module prog_loader #(
    parameter int OPBTS    = 5,
    parameter int OPRBTS   = 11,
    parameter int ADDR_BTS = 11,
    parameter int DBTS     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [DBTS-1:0]         i_rx_data,
    input  logic                    i_rx_done,
    output logic                    o_wr_en,
    output logic [ADDR_BTS-1:0]     o_wr_addr,
    output logic [OPBTS+OPRBTS-1:0] o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [1:0]              o_err,
    output logic [ADDR_BTS:0]       o_count
);

    localparam int IW = OPBTS + OPRBTS;

    // Highest implemented op_code (SUBI); HLT is op_code 0.
    localparam logic [OPBTS-1:0]    OP_MAX   = OPBTS'(7);
    localparam logic [OPBTS-1:0]    OP_HLT   = '0;
    localparam logic [ADDR_BTS-1:0] ADDR_MAX = '1;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_OVFL   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    logic [DBTS-1:0]     hi_byte;
    logic [ADDR_BTS-1:0] addr;

    logic [OPBTS-1:0] rx_op;
    logic [OPBTS-1:0] hi_op;

    // op_code fields of the incoming byte and of the latched high byte.
    assign rx_op = i_rx_data[DBTS-1 -: OPBTS];
    assign hi_op = hi_byte[DBTS-1 -: OPBTS];

    // Session FSM with all outputs registered; the write pulse lands one
    // cycle after the low-byte strobe and the FSM is already back in
    // S_WAIT_HI, so a strobe in the write cycle is taken as the next high byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            hi_byte   <= '0;
            addr      <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= ERR_NONE;
            o_count   <= '0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // A strobe coinciding with start is discarded.
                    if (i_start) begin
                        state   <= S_WAIT_HI;
                        addr    <= '0;
                        o_count <= '0;
                        o_err   <= ERR_NONE;
                        o_done  <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (i_rx_done) begin
                        hi_byte <= i_rx_data;
                        if (rx_op > OP_MAX) begin
                            state  <= S_ERR;
                            o_err  <= ERR_OPCODE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= S_WAIT_LO;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (i_rx_done) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= addr;
                        o_wr_data <= IW'({hi_byte, i_rx_data});
                        o_count   <= o_count + (ADDR_BTS+1)'(1);
                        if (hi_op == OP_HLT) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else if (addr == ADDR_MAX) begin
                            state  <= S_ERR;
                            o_err  <= ERR_OVFL;
                            o_busy <= 1'b0;
                        end else begin
                            addr  <= addr + ADDR_BTS'(1);
                            state <= S_WAIT_HI;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with a 4-word program memory (ADDR_BTS=2), so
// that both a full HLT-terminated program and overflow fit in one run.
// Expected writes go into a queue when the low byte is sent; a monitor
// pops and compares address, data and arrival cycle of every write.
module tb_prog_loader;

    localparam int OPBTS    = 5;
    localparam int OPRBTS   = 11;
    localparam int ADDR_BTS = 2;
    localparam int DBTS     = 8;
    localparam int IW       = OPBTS + OPRBTS;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_start = 1'b0;
    logic [DBTS-1:0]     i_rx_data = '0;
    logic                i_rx_done = 1'b0;
    logic                o_wr_en;
    logic [ADDR_BTS-1:0] o_wr_addr;
    logic [IW-1:0]       o_wr_data;
    logic                o_busy;
    logic                o_done;
    logic [1:0]          o_err;
    logic [ADDR_BTS:0]   o_count;

    prog_loader #(
        .OPBTS(OPBTS), .OPRBTS(OPRBTS), .ADDR_BTS(ADDR_BTS), .DBTS(DBTS)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int unsigned cyc;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (t=%0t)",
                         o_wr_addr, o_wr_data, $time);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(o_wr_addr), e.addr);
                chk("wr_data", 32'(o_wr_data), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // All stimulus tasks start and end at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    // Low byte: the write is expected on the cycle after the strobe edge.
    task automatic send_lo(input logic [7:0] b, input int unsigned a, input int unsigned w);
        wr_exp_t e;
        e.addr = a;
        e.data = w;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        send(b);
    endtask

    task automatic chk_status(input string tag, input logic busy, input logic done,
                              input logic [1:0] err, input int unsigned count);
        chk({tag, "_busy"}, 32'(o_busy), 32'(busy));
        chk({tag, "_done"}, 32'(o_done), 32'(done));
        chk({tag, "_err"}, 32'(o_err), 32'(err));
        chk({tag, "_count"}, 32'(o_count), count);
    endtask

    initial begin
        // Reset state
        #1;
        chk_status("rst", 1'b0, 1'b0, 2'b00, 0);
        chk("rst_wr_en", 32'(o_wr_en), 0);
        chk("rst_wr_addr", 32'(o_wr_addr), 0);
        chk("rst_wr_data", 32'(o_wr_data), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        idle(1);

        // Reset mid-load: high byte taken, then async reset aborts
        pulse_start();
        chk("start_busy", 32'(o_busy), 1);
        send(8'h28);
        i_rst = 1'b1;
        #1;
        chk_status("midrst", 1'b0, 1'b0, 2'b00, 0);
        chk("midrst_wr_en", 32'(o_wr_en), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        send(8'h05);
        idle(2);
        chk_status("midrst_after", 1'b0, 1'b0, 2'b00, 0);

        // Normal program: LDI 5, ADDI 3, STO 16, HLT
        pulse_start();
        send(8'h18); idle(1); send_lo(8'h05, 0, 16'h1805); idle(2);
        chk_status("prog_mid", 1'b1, 1'b0, 2'b00, 1);
        send(8'h28); idle(1); send_lo(8'h03, 1, 16'h2803); idle(1);
        send(8'h08); send_lo(8'h10, 2, 16'h0810); idle(3);
        send(8'h00); idle(2); send_lo(8'h00, 3, 16'h0000); idle(2);
        chk_status("prog_end", 1'b0, 1'b1, 2'b00, 4);

        // Invalid op_code 8: error next cycle, no write
        pulse_start();
        send(8'h40);
        chk_status("badop", 1'b0, 1'b0, 2'b01, 0);
        idle(2);
        chk("badop_hold", 32'(o_err), 32'(2'b01));

        // Restart clears the error; back-to-back strobes from address 0
        pulse_start();
        chk_status("restart", 1'b1, 1'b0, 2'b00, 0);
        send(8'h10);
        send_lo(8'h07, 0, 16'h1007);
        send(8'h00);
        send_lo(8'h00, 1, 16'h0000);
        idle(2);
        chk_status("b2b", 1'b0, 1'b1, 2'b00, 2);

        // Overflow: four non-HLT words fill the 4-word memory
        pulse_start();
        send(8'h08); send_lo(8'h01, 0, 16'h0801);
        send(8'h10); send_lo(8'h02, 1, 16'h1002);
        send(8'h18); send_lo(8'h03, 2, 16'h1803);
        send(8'h38); send_lo(8'hFF, 3, 16'h38FF);
        idle(2);
        chk_status("ovfl", 1'b0, 1'b0, 2'b10, 4);
        send(8'h00);
        idle(1);
        chk("ovfl_rx_ignored", 32'(o_err), 32'(2'b10));

        // Ignored inputs: byte in IDLE after reset
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        send(8'h18);
        idle(1);
        chk_status("idle_rx", 1'b0, 1'b0, 2'b00, 0);

        // Start with a simultaneous strobe: start taken, byte discarded
        i_start   = 1'b1;
        i_rx_data = 8'h40;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_start   = 1'b0;
        i_rx_done = 1'b0;
        chk_status("start_rx", 1'b1, 1'b0, 2'b00, 0);

        // Start during WAIT_LO / WAIT_HI does not restart the session
        send(8'h18);
        pulse_start();
        send_lo(8'h22, 0, 16'h1822);
        pulse_start();
        chk_status("start_ign", 1'b1, 1'b0, 2'b00, 1);
        send(8'h00);
        send_lo(8'h00, 1, 16'h0000);
        idle(2);
        chk_status("ign_end", 1'b0, 1'b1, 2'b00, 2);

        idle(2);
        chk("pending_writes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
